// File: rtl/bit32_shift_pkg.sv
// bit32_shift_pkg
//   Shared encodings for the sequential 32-bit shift unit:
//   operation select codes, FSM state encoding and the fixed
//   shift distance used by the LUI-pack operation.
package bit32_shift_pkg;

   typedef enum logic [1:0] {
      OP_SLL  = 2'b00,
      OP_SRL  = 2'b01,
      OP_SRA  = 2'b10,
      OP_LUIP = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // LUI-pack is a left shift by a half-word.
   localparam int LUI_SHAMT = 16;

endpackage

// File: rtl/bit32_shift_step.sv
// bit32_shift_step
//   Combinational single-position shifter.
//   Ports:
//     val_i  in  WIDTH  value to shift
//     op_i   in  op_e   operation (SLL/LUI-pack shift left, SRL/SRA right)
//     val_o  out WIDTH  value shifted by one position
module bit32_shift_step
   import bit32_shift_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] val_i,
   input  op_e              op_i,
   output logic [WIDTH-1:0] val_o
);

   always_comb begin
      val_o = val_i;
      case (op_i)
         OP_SLL, OP_LUIP: val_o = {val_i[WIDTH-2:0], 1'b0};
         OP_SRL:          val_o = {1'b0, val_i[WIDTH-1:1]};
         // Arithmetic: the sign bit is replicated into the vacated MSB.
         OP_SRA:          val_o = {val_i[WIDTH-1], val_i[WIDTH-1:1]};
         default:         val_o = val_i;
      endcase
   end

endmodule

// File: rtl/bit32_seq_shifter.sv
// bit32_seq_shifter
//   Multi-cycle shift unit: one bit position per clock under a
//   start/busy/done handshake. Implements SLL, SRL, SRA and LUI-pack.
//   Ports:
//     clk     in   clock, rising edge
//     rst     in   synchronous active-high reset
//     start   in   request, sampled in IDLE or DONE only
//     op      in   2-bit op select (00 SLL, 01 SRL, 10 SRA, 11 LUI-pack)
//     shamt   in   SHW-bit shift amount (ignored for LUI-pack)
//     a       in   WIDTH-bit operand, sampled with start
//     result  out  accumulator; valid while done is high
//     busy    out  high in RUN
//     done    out  one-cycle pulse in DONE
module bit32_seq_shifter
   import bit32_shift_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [SHW-1:0]   shamt,
   input  logic [WIDTH-1:0] a,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   op_e              op_q, op_d;
   logic [WIDTH-1:0] step_val;

   bit32_shift_step #(.WIDTH(WIDTH)) u_step (
      .val_i (acc_q),
      .op_i  (op_q),
      .val_o (step_val)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               acc_d   = a;
               op_d    = op_e'(op);
               cnt_d   = (op == OP_LUIP) ? SHW'(LUI_SHAMT) : shamt;
               state_d = ST_RUN;
            end else if (state_q == ST_DONE) begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            // One extra edge at count 0 moves to DONE, so latency is n+1.
            if (cnt_q != '0) begin
               acc_d = step_val;
               cnt_d = cnt_q - SHW'(1);
            end else begin
               state_d = ST_DONE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         op_q    <= OP_SLL;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
      end
   end

   assign result = acc_q;
   assign busy   = (state_q == ST_RUN);
   assign done   = (state_q == ST_DONE);

endmodule

// File: tb/tb_bit32_seq_shifter.sv
module tb_bit32_seq_shifter;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [1:0]  op;
   logic [4:0]  shamt;
   logic [31:0] a;
   logic [31:0] result;
   logic        busy;
   logic        done;

   int total = 0;
   int bad   = 0;

   bit32_seq_shifter #(.WIDTH(32), .SHW(5)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .op     (op),
      .shamt  (shamt),
      .a      (a),
      .result (result),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   // Reference model: whole-word arithmetic on the architectural rules.
   function automatic logic [31:0] ref_val(input logic [1:0] o, input logic [31:0] v,
                                           input logic [4:0] s);
      logic [31:0] r;
      case (o)
         2'd0:    r = v << s;
         2'd1:    r = v >> s;
         2'd2:    r = 32'($signed(v) >>> s);
         default: r = {v[15:0], 16'h0000};
      endcase
      return r;
   endfunction

   function automatic int ref_lat(input logic [1:0] o, input logic [4:0] s);
      return (o == 2'd3) ? 17 : int'(s) + 1;
   endfunction

   // Drives one request (caller is #1 after an edge) and waits for done.
   // lat = edges after the start edge until done is seen; bcnt = busy cycles.
   task automatic launch(input logic [1:0] o, input logic [31:0] av, input logic [4:0] sh,
                         output int lat, output int bcnt, output bit to);
      start = 1'b1; op = o; a = av; shamt = sh;
      @(posedge clk); #1;
      start = 1'b0; op = 2'($urandom); a = $urandom; shamt = 5'($urandom);
      lat = 0; bcnt = 0; to = 1'b0;
      while (done !== 1'b1) begin
         if (busy === 1'b1) bcnt++;
         if (lat >= 60) begin to = 1'b1; break; end
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      int lat, bcnt; bit to;
      rst = 1'b1; start = 1'b0; op = 2'd0; shamt = '0; a = '0;
      repeat (2) @(posedge clk);
      #1;
      total++;
      if (result !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++;
         $display("FAIL reset_init: result=%h busy=%b done=%b want 0/0/0", result, busy, done);
      end
      rst = 1'b0;
      // Start a long SLL and reset in the middle of it.
      start = 1'b1; op = 2'd0; a = 32'h0000_0001; shamt = 5'd31;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++;
         if (result !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid[%0d]: result=%h busy=%b done=%b want 0/0/0",
                     i, result, busy, done);
         end
      end
      rst = 1'b0;
      @(posedge clk); #1;
      launch(2'd1, 32'hF000_0000, 5'd4, lat, bcnt, to);
      total++;
      if (to || result !== 32'h0F00_0000 || lat != 5) begin
         bad++;
         $display("FAIL reset_after: result=%h lat=%0d to=%0d want 0f000000 lat=5",
                  result, lat, to);
      end
   endtask

   task automatic test_sll;
      int lat, bcnt; bit to;
      launch(2'd0, 32'h0000_0001, 5'd31, lat, bcnt, to);
      total++;
      if (to || result !== 32'h8000_0000) begin
         bad++;
         $display("FAIL sll31_result: got %h want 80000000 to=%0d", result, to);
      end
      total++;
      if (lat != 32 || bcnt != 32) begin
         bad++;
         $display("FAIL sll31_timing: lat=%0d busy=%0d want 32/32", lat, bcnt);
      end
   endtask

   task automatic test_right;
      int lat, bcnt; bit to;
      launch(2'd2, 32'h8000_00F0, 5'd4, lat, bcnt, to);
      total++;
      if (to || result !== 32'hF800_000F || lat != 5) begin
         bad++;
         $display("FAIL sra4: got %h lat=%0d want f800000f lat=5", result, lat);
      end
      @(posedge clk); #1;
      launch(2'd1, 32'h8000_00F0, 5'd4, lat, bcnt, to);
      total++;
      if (to || result !== 32'h0800_000F || lat != 5) begin
         bad++;
         $display("FAIL srl4: got %h lat=%0d want 0800000f lat=5", result, lat);
      end
   endtask

   task automatic test_luip;
      int lat, bcnt; bit to;
      @(posedge clk); #1;
      launch(2'd3, 32'h1234_ABCD, 5'd7, lat, bcnt, to);
      total++;
      if (to || result !== 32'hABCD_0000 || lat != 17 || bcnt != 17) begin
         bad++;
         $display("FAIL luip: got %h lat=%0d busy=%0d want abcd0000 17/17",
                  result, lat, bcnt);
      end
   endtask

   task automatic test_back_to_back;
      int lat, bcnt; bit to;
      @(posedge clk); #1;
      launch(2'd0, 32'hDEAD_BEEF, 5'd0, lat, bcnt, to);
      total++;
      if (to || result !== 32'hDEAD_BEEF || lat != 1 || bcnt != 1) begin
         bad++;
         $display("FAIL zero_shift: got %h lat=%0d busy=%0d want deadbeef 1/1",
                  result, lat, bcnt);
      end
      // Still in the DONE cycle: request again, accepted on this edge.
      launch(2'd1, 32'hDEAD_BEEF, 5'd8, lat, bcnt, to);
      total++;
      if (to || result !== 32'h00DE_ADBE || lat != 9 || bcnt != 9) begin
         bad++;
         $display("FAIL b2b_srl8: got %h lat=%0d busy=%0d want 00deadbe 9/9",
                  result, lat, bcnt);
      end
   endtask

   task automatic test_start_busy;
      int lat; bit seen;
      @(posedge clk); #1;
      start = 1'b1; op = 2'd1; a = 32'h8000_0000; shamt = 5'd10;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0; seen = 1'b0;
      for (int i = 0; i < 40 && !seen; i++) begin
         if (i == 2) begin start = 1'b1; op = 2'd0; a = 32'h0000_FFFF; shamt = 5'd1; end
         else start = 1'b0;
         if (done === 1'b1) seen = 1'b1;
         else begin @(posedge clk); #1; lat++; end
      end
      start = 1'b0;
      total++;
      if (!seen || result !== 32'h0020_0000 || lat != 11) begin
         bad++;
         $display("FAIL start_busy: got %h lat=%0d seen=%0d want 00200000 lat=11",
                  result, lat, seen);
      end
   endtask

   task automatic test_random;
      int lat, bcnt; bit to;
      logic [1:0] o; logic [31:0] v; logic [4:0] s; logic [31:0] exp;
      for (int k = 0; k < 24; k++) begin
         o = 2'($urandom_range(0, 3)); v = $urandom; s = 5'($urandom);
         exp = ref_val(o, v, s);
         launch(o, v, s, lat, bcnt, to);
         total++;
         if (to || result !== exp || lat != ref_lat(o, s) || bcnt != ref_lat(o, s)) begin
            bad++;
            $display("FAIL rand[%0d] op=%0d a=%h sh=%0d: got %h lat=%0d busy=%0d want %h lat=%0d",
                     k, o, v, s, result, lat, bcnt, exp, ref_lat(o, s));
         end
         // done is a single pulse and result holds into IDLE.
         @(posedge clk); #1;
         total++;
         if (done !== 1'b0 || busy !== 1'b0 || result !== exp) begin
            bad++;
            $display("FAIL rand_idle[%0d]: done=%b busy=%b result=%h want 0/0/%h",
                     k, done, busy, result, exp);
         end
      end
   endtask

   initial begin
      test_reset;
      test_sll;
      test_right;
      test_luip;
      test_back_to_back;
      test_start_busy;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
